// File: rtl/sal_bk_sched_if.sv
// Shared types, timing monitor interface and the bank request /
// DRAM command bus of the sal_bk_sched command scheduler.
package sal_bk_pkg;
    typedef logic [2:0]  dram_ba_t;
    typedef logic [15:0] dram_ra_t;
    typedef logic [9:0]  dram_ca_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [7:0]  seq_num_t;
    typedef logic [3:0]  t_cnt_t;

    typedef struct packed {
        logic     act_req;
        logic     rd_req;
        logic     wr_req;
        logic     pre_req;
        logic     ref_req;
        dram_ba_t ba;
        dram_ra_t ra;
        dram_ca_t ca;
        axi_id_t  id;
        axi_len_t len;
        seq_num_t seq_num;
    } bk_req_t;

    typedef struct packed {
        logic act_gnt;
        logic rd_gnt;
        logic wr_gnt;
        logic pre_gnt;
        logic ref_gnt;
    } bk_gnt_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;
endpackage

interface TIMING_IF;
    import sal_bk_pkg::*;

    t_cnt_t t_rrd_m1;
    t_cnt_t t_ccd_m1;
    t_cnt_t t_wtr_m1;
    t_cnt_t t_rtw_m1;

    modport MON (
        input t_rrd_m1,
        input t_ccd_m1,
        input t_wtr_m1,
        input t_rtw_m1
    );

    modport CFG (
        output t_rrd_m1,
        output t_ccd_m1,
        output t_wtr_m1,
        output t_rtw_m1
    );
endinterface

interface sal_bk_sched_if #(
    parameter int NUM_BANKS = 4
);
    import sal_bk_pkg::*;

    bk_req_t    bk_reqs_i [NUM_BANKS];
    bk_gnt_t    bk_gnts_o [NUM_BANKS];
    logic       cmd_valid_o;
    logic [2:0] cmd_type_o;
    dram_ba_t   cmd_ba_o;
    dram_ra_t   cmd_ra_o;
    dram_ca_t   cmd_ca_o;
    axi_id_t    cmd_id_o;
    axi_len_t   cmd_len_o;
    seq_num_t   cmd_seq_o;

    modport master (
        input  bk_reqs_i,
        output bk_gnts_o,
        output cmd_valid_o,
        output cmd_type_o,
        output cmd_ba_o,
        output cmd_ra_o,
        output cmd_ca_o,
        output cmd_id_o,
        output cmd_len_o,
        output cmd_seq_o
    );

    modport slave (
        output bk_reqs_i,
        input  bk_gnts_o,
        input  cmd_valid_o,
        input  cmd_type_o,
        input  cmd_ba_o,
        input  cmd_ra_o,
        input  cmd_ca_o,
        input  cmd_id_o,
        input  cmd_len_o,
        input  cmd_seq_o
    );
endinterface

// File: rtl/sal_bk_sched.sv
// Inter-bank DRAM command scheduler: class priority, per-class
// round-robin, tRRD/tCCD/tWTR/tRTW gating, registered command bus.
module sal_bk_sched
    import sal_bk_pkg::*;
#(
    parameter int NUM_BANKS = 4
) (
    input  logic           clk,
    input  logic           rst,
    TIMING_IF.MON          timing_if,
    sal_bk_sched_if.master bus
);
    localparam int PW = $clog2(NUM_BANKS);

    typedef logic [PW-1:0]        ptr_t;
    typedef logic [NUM_BANKS-1:0] vec_t;

    bk_req_t reqs [NUM_BANKS];
    bk_gnt_t gnts [NUM_BANKS];

    assign reqs          = bus.bk_reqs_i;
    assign bus.bk_gnts_o = gnts;

    t_cnt_t rrd_cnt;
    t_cnt_t ccd_cnt;
    t_cnt_t rtw_cnt;
    t_cnt_t wtr_cnt;

    ptr_t ref_ptr;
    ptr_t cas_ptr;
    ptr_t act_ptr;
    ptr_t pre_ptr;

    vec_t ref_el;
    vec_t rd_el;
    vec_t wr_el;
    vec_t act_el;
    vec_t pre_el;

    logic act_ok;
    logic rd_ok;
    logic wr_ok;

    logic [PW:0] ref_pk;
    logic [PW:0] cas_pk;
    logic [PW:0] act_pk;
    logic [PW:0] pre_pk;

    logic    g_valid;
    cmd_e    g_type;
    ptr_t    g_bank;
    bk_req_t g_req;

    logic ld_act;
    logic ld_rd;
    logic ld_wr;

    // First set bit at or after p, wrapping; MSB flags a hit.
    function automatic logic [PW:0] rr_pick(
        input vec_t v,
        input ptr_t p
    );
        logic [PW:0] r;
        ptr_t        idx;
        r = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            idx = p + ptr_t'(i);
            if (v[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    function automatic t_cnt_t dec(input t_cnt_t c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    assign act_ok = (rrd_cnt == '0);
    assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);

    always_comb begin
        ref_el = '0;
        rd_el  = '0;
        wr_el  = '0;
        act_el = '0;
        pre_el = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            ref_el[b] = reqs[b].ref_req;
            rd_el[b]  = reqs[b].rd_req & rd_ok;
            wr_el[b]  = reqs[b].wr_req & wr_ok;
            act_el[b] = reqs[b].act_req & act_ok;
            pre_el[b] = reqs[b].pre_req;
        end
    end

    assign ref_pk = rr_pick(ref_el, ref_ptr);
    assign cas_pk = rr_pick(rd_el | wr_el, cas_ptr);
    assign act_pk = rr_pick(act_el, act_ptr);
    assign pre_pk = rr_pick(pre_el, pre_ptr);

    always_comb begin
        g_valid = 1'b0;
        g_type  = CMD_NOP;
        g_bank  = '0;
        if (ref_pk[PW]) begin
            g_valid = 1'b1;
            g_type  = CMD_REF;
            g_bank  = ref_pk[PW-1:0];
        end else if (cas_pk[PW]) begin
            g_valid = 1'b1;
            g_bank  = cas_pk[PW-1:0];
            // A bank raising both RD and WR gets RD.
            g_type  = rd_el[g_bank] ? CMD_RD : CMD_WR;
        end else if (act_pk[PW]) begin
            g_valid = 1'b1;
            g_type  = CMD_ACT;
            g_bank  = act_pk[PW-1:0];
        end else if (pre_pk[PW]) begin
            g_valid = 1'b1;
            g_type  = CMD_PRE;
            g_bank  = pre_pk[PW-1:0];
        end
    end

    assign g_req = reqs[g_bank];

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnts[b] = '0;
            if (!rst && g_valid && g_bank == ptr_t'(b)) begin
                unique case (g_type)
                    CMD_ACT: gnts[b].act_gnt = 1'b1;
                    CMD_RD:  gnts[b].rd_gnt  = 1'b1;
                    CMD_WR:  gnts[b].wr_gnt  = 1'b1;
                    CMD_PRE: gnts[b].pre_gnt = 1'b1;
                    CMD_REF: gnts[b].ref_gnt = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign ld_act = g_valid && (g_type == CMD_ACT);
    assign ld_rd  = g_valid && (g_type == CMD_RD);
    assign ld_wr  = g_valid && (g_type == CMD_WR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            rtw_cnt <= '0;
            wtr_cnt <= '0;
            ref_ptr <= '0;
            cas_ptr <= '0;
            act_ptr <= '0;
            pre_ptr <= '0;
        end else begin
            rrd_cnt <= ld_act ? timing_if.t_rrd_m1 : dec(rrd_cnt);
            ccd_cnt <= (ld_rd || ld_wr) ? timing_if.t_ccd_m1
                                        : dec(ccd_cnt);
            rtw_cnt <= ld_rd ? timing_if.t_rtw_m1 : dec(rtw_cnt);
            wtr_cnt <= ld_wr ? timing_if.t_wtr_m1 : dec(wtr_cnt);
            if (g_valid) begin
                unique case (g_type)
                    CMD_REF:        ref_ptr <= g_bank + 1'b1;
                    CMD_RD, CMD_WR: cas_ptr <= g_bank + 1'b1;
                    CMD_ACT:        act_ptr <= g_bank + 1'b1;
                    CMD_PRE:        pre_ptr <= g_bank + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cmd_valid_o <= 1'b0;
            bus.cmd_type_o  <= CMD_NOP;
            bus.cmd_ba_o    <= '0;
            bus.cmd_ra_o    <= '0;
            bus.cmd_ca_o    <= '0;
            bus.cmd_id_o    <= '0;
            bus.cmd_len_o   <= '0;
            bus.cmd_seq_o   <= '0;
        end else begin
            bus.cmd_valid_o <= g_valid;
            bus.cmd_type_o  <= g_type;
            if (g_valid) begin
                bus.cmd_ba_o  <= g_req.ba;
                bus.cmd_ra_o  <= g_req.ra;
                bus.cmd_ca_o  <= g_req.ca;
                bus.cmd_id_o  <= g_req.id;
                bus.cmd_len_o <= g_req.len;
                bus.cmd_seq_o <= g_req.seq_num;
            end
        end
    end
endmodule
